// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access.
// Registered capture, variable-latency completion via M_READY, watchdog abort with error ack.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_ACK,
  output logic [DW-1:0] IF_RDATA,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  output logic          ERR,
  output logic          BUSY,
  output logic          M_EN,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA,
  input  logic          M_READY
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          own_d, own_d_n;
  logic          last_d, last_d_n;
  logic          we_q, we_n;
  logic [WW-1:0] wd, wd_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;
  logic [DW-1:0] if_rd_n, d_rd_n;
  logic          err_n, ack_n;

  always_comb begin
    state_n  = state;
    own_d_n  = own_d;
    last_d_n = last_d;
    we_n     = we_q;
    wd_n     = wd;
    addr_n   = M_ADDR;
    wdata_n  = M_WDATA;
    if_rd_n  = IF_RDATA;
    d_rd_n   = D_RDATA;
    err_n    = 1'b0;
    ack_n    = 1'b0;
    case (state)
      IDLE: begin
        if (IF_REQ || D_REQ) begin
          // On a tie the requester that was not served last wins.
          own_d_n  = D_REQ && (!IF_REQ || !last_d);
          last_d_n = own_d_n;
          addr_n   = own_d_n ? D_ADDR : IF_ADDR;
          we_n     = own_d_n && D_WE;
          wdata_n  = own_d_n ? D_WDATA : '0;
          wd_n     = '0;
          state_n  = ACCESS;
        end
      end
      ACCESS: begin
        if (M_READY) begin
          if (!we_q) begin
            if (own_d) d_rd_n  = M_RDATA;
            else       if_rd_n = M_RDATA;
          end
          ack_n   = 1'b1;
          state_n = DONE;
        end else if (wd == WD_LAST) begin
          err_n   = 1'b1;
          ack_n   = 1'b1;
          state_n = DONE;
        end else begin
          wd_n = wd + WW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      own_d    <= 1'b0;
      last_d   <= 1'b1;
      we_q     <= 1'b0;
      wd       <= '0;
      M_ADDR   <= '0;
      M_WDATA  <= '0;
      M_EN     <= 1'b0;
      M_WE     <= 1'b0;
      IF_ACK   <= 1'b0;
      D_ACK    <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
      IF_RDATA <= '0;
      D_RDATA  <= '0;
    end else begin
      state    <= state_n;
      own_d    <= own_d_n;
      last_d   <= last_d_n;
      we_q     <= we_n;
      wd       <= wd_n;
      M_ADDR   <= addr_n;
      M_WDATA  <= wdata_n;
      M_EN     <= (state_n == ACCESS);
      M_WE     <= (state_n == ACCESS) && we_n;
      IF_ACK   <= ack_n && !own_d_n;
      D_ACK    <= ack_n && own_d_n;
      ERR      <= err_n;
      BUSY     <= (state_n != IDLE);
      IF_RDATA <= if_rd_n;
      D_RDATA  <= d_rd_n;
    end
  end

endmodule
